full_adder: RTL and testbench
=============================

Name: full_adder

Overview:
- Registered, width-parameterised ripple-carry full adder.
- Computes {carry_out, sum} = a + b + carry_in and registers the result one clock later, tagged with a valid strobe.
- Leaf arithmetic block used by datapath stages and by small counter/accumulator wrappers.
- Default WIDTH=1 gives the classic single-bit full adder with a register stage.

Parameters:
- WIDTH, 1, operand and sum width in bits (legal range 1..64).

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous reset, active-high.
- in_valid  input  1  operands valid this cycle.
- a  input  WIDTH  operand A (unsigned).
- b  input  WIDTH  operand B (unsigned).
- carry_in  input  1  carry into bit 0.
- sum  output  WIDTH  registered sum bits.
- carry_out  output  1  registered carry out of the MSB.
- out_valid  output  1  sum/carry_out updated on the previous edge.

Behaviour:
- Interface: one clock (clk); reset rst is synchronous and active-high.
- Reset: when rst=1 at a rising edge, sum=0, carry_out=0, out_valid=0. rst has priority over in_valid; operands presented during reset are dropped.
- Arithmetic: the result is the (WIDTH+1)-bit exact sum a+b+carry_in.
  - sum = low WIDTH bits.
  - carry_out = bit WIDTH.
  - No saturation; wrap-around is expressed only through carry_out.
- Structure: ripple chain of WIDTH one-bit cells. Per cell:
  - s_i = a_i ^ b_i ^ c_i
  - c_{i+1} = (a_i & b_i) | (c_i & (a_i ^ b_i))
  - c_0 = carry_in; carry_out = c_WIDTH.
- Latency: exactly 1 cycle. Operands sampled at edge N with in_valid=1 appear on sum/carry_out after edge N, with out_valid=1 for that one cycle.
- Back-to-back: in_valid may be high every cycle; throughput is 1 result per clock. There is no backpressure and no ready signal.
- Idle: in_valid=0 at an edge gives out_valid=0; sum/carry_out hold their last values.
- Reset mid-stream: a result in flight is discarded; the first post-reset result requires a new in_valid.
- X-safety: with in_valid=0, operand X values must not propagate into the held outputs.

Optional Feature:
- Macro FULL_ADDER_OVERFLOW_EN.
- Defined: adds output port overflow (1 bit, registered alongside sum).
  - overflow = c_WIDTH ^ c_{WIDTH-1}, i.e. two's-complement signed overflow.
  - For WIDTH=1, overflow = carry_out ^ carry_in.
  - Resets to 0; holds when in_valid=0.
- Undefined: the port and its logic are absent; all other behaviour is identical.

Decomposition:
- Package full_adder_pkg:
  - constant FA_MAX_WIDTH = 64.
  - typedef fa_result_t, a packed struct {carry_out, overflow, sum}, sized by a package-level default width.
  - Function fa_ref(a, b, cin), a golden model used by the bench.
- Sub-module full_adder_bit: purely combinational one-bit cell with ports a, b, ci, s, co, instantiated WIDTH times in a generate loop. The top level holds only the chain and the output registers.

Test Plan:
- Reset: assert rst for 2 cycles while driving a=1, b=1, carry_in=1, in_valid=1. Required: sum=0, carry_out=0, out_valid=0 throughout reset. First result (sum=1, carry_out=1) appears one cycle after rst deasserts.
- WIDTH=1 truth table, driven back-to-back with in_valid=1, as (a,b,cin) -> (sum,cout), each result one cycle later:
  - 000 -> 0,0
  - 100 -> 1,0
  - 010 -> 1,0
  - 001 -> 1,0
  - 110 -> 0,1
  - 101 -> 0,1
  - 111 -> 1,1
  - 011 -> 0,1
- WIDTH=8 boundaries:
  - a=0xFF, b=0x00, cin=1 -> sum=0x00, carry_out=1.
  - a=0x7F, b=0x01, cin=0 -> sum=0x80, carry_out=0, and with FULL_ADDER_OVERFLOW_EN, overflow=1.
  - a=0x80, b=0x80, cin=0 -> sum=0x00, carry_out=1, overflow=1.
- Hold/idle: after result 0x5A, drop in_valid for 3 cycles while toggling operands randomly. Required: out_valid=0 and sum stays 0x5A.
- Reset mid-stream (WIDTH=8): drive a=0x10, b=0x20, then assert rst on the next edge. Required: out_valid=0 and sum=0x00; result 0x30 is never emitted.
- Random: 10,000 random WIDTH=16 vectors with random in_valid, compared against fa_ref with 1-cycle alignment. Required: zero mismatches.

Source files
------------

// File: rtl/full_adder_pkg.sv
// ============================================================================
// Module   : full_adder_pkg
// Purpose  : Shared width limit, result record and golden arithmetic model.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package full_adder_pkg;

  localparam int unsigned FA_MAX_WIDTH     = 64;
  localparam int unsigned FA_DEFAULT_WIDTH = 16;

  typedef struct packed {
    logic                        carry_out;
    logic                        overflow;
    logic [FA_DEFAULT_WIDTH-1:0] sum;
  } fa_result_t;

  // Plain-arithmetic reference; overflow is signed overflow of a+b+cin.
  function automatic fa_result_t fa_ref(
    input logic [FA_DEFAULT_WIDTH-1:0] a,
    input logic [FA_DEFAULT_WIDTH-1:0] b,
    input logic                        cin
  );
    fa_result_t                r;
    logic [FA_DEFAULT_WIDTH:0] full;
    full        = {1'b0, a} + {1'b0, b} + {{FA_DEFAULT_WIDTH{1'b0}}, cin};
    r.sum       = full[FA_DEFAULT_WIDTH-1:0];
    r.carry_out = full[FA_DEFAULT_WIDTH];
    r.overflow  = (a[FA_DEFAULT_WIDTH-1] == b[FA_DEFAULT_WIDTH-1]) &&
                  (r.sum[FA_DEFAULT_WIDTH-1] != a[FA_DEFAULT_WIDTH-1]);
    return r;
  endfunction

endpackage

`default_nettype wire

// File: rtl/full_adder_bit.sv
// ============================================================================
// Module   : full_adder_bit
// Purpose  : Combinational one-bit full-adder cell of the ripple chain.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module full_adder_bit
  import full_adder_pkg::*;
(
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);

  logic w_p;

  assign w_p = a ^ b;
  assign s   = w_p ^ ci;
  assign co  = (a & b) | (ci & w_p);

endmodule

`default_nettype wire

// File: rtl/full_adder.sv
// ============================================================================
// Module   : full_adder
// Purpose  : Registered WIDTH-bit ripple-carry adder, 1-cycle latency.
//            Optional macro FULL_ADDER_OVERFLOW_EN adds a signed overflow port.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module full_adder
  import full_adder_pkg::*;
#(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             carry_in,
  output logic [WIDTH-1:0] sum,
  output logic             carry_out,
`ifdef FULL_ADDER_OVERFLOW_EN
  output logic             overflow,
`endif
  output logic             out_valid
);

  logic [WIDTH:0]   w_c;
  logic [WIDTH-1:0] w_s;
  logic [WIDTH-1:0] r_sum;
  logic             r_carry;
  logic             r_valid;

  assign w_c[0] = carry_in;

  for (genvar i = 0; i < WIDTH; i++) begin : g_cell
    full_adder_bit u_bit (
      .a  (a[i]),
      .b  (b[i]),
      .ci (w_c[i]),
      .s  (w_s[i]),
      .co (w_c[i+1])
    );
  end

  // Data registers load only on in_valid so idle X operands never reach them.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_sum   <= '0;
      r_carry <= 1'b0;
      r_valid <= 1'b0;
    end else begin
      r_valid <= in_valid;
      if (in_valid) begin
        r_sum   <= w_s;
        r_carry <= w_c[WIDTH];
      end
    end
  end

`ifdef FULL_ADDER_OVERFLOW_EN
  logic r_ovf;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_ovf <= 1'b0;
    end else if (in_valid) begin
      r_ovf <= w_c[WIDTH] ^ w_c[WIDTH-1];
    end
  end

  assign overflow = r_ovf;
`endif

  assign sum       = r_sum;
  assign carry_out = r_carry;
  assign out_valid = r_valid;

endmodule

`default_nettype wire

// File: tb/tb_full_adder.sv
// ============================================================================
// Module   : tb_full_adder
// Purpose  : Scoreboard bench for full_adder at WIDTH = 1, 8 and 16.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_full_adder;
  import full_adder_pkg::*;

  typedef struct packed {
    logic [63:0] s;
    logic        co;
    logic        ov;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic        v1 = 0, a1 = 0, b1 = 0, c1 = 0, s1, co1, of1, ov1;
  logic        v8 = 0, c8 = 0, co8, of8, ov8;
  logic [7:0]  a8 = 0, b8 = 0, s8;
  logic        v16 = 0, c16 = 0, co16, of16, ov16;
  logic [15:0] a16 = 0, b16 = 0, s16;

  exp_t q1[$], q8[$], q16[$];
  exp_t e1, e8, e16;
  int   n_vec = 0;
  int   n_bad = 0;

  full_adder #(.WIDTH(1)) u_w1 (
    .clk(clk), .rst(rst), .in_valid(v1), .a(a1), .b(b1), .carry_in(c1),
    .sum(s1), .carry_out(co1),
`ifdef FULL_ADDER_OVERFLOW_EN
    .overflow(of1),
`endif
    .out_valid(ov1));

  full_adder #(.WIDTH(8)) u_w8 (
    .clk(clk), .rst(rst), .in_valid(v8), .a(a8), .b(b8), .carry_in(c8),
    .sum(s8), .carry_out(co8),
`ifdef FULL_ADDER_OVERFLOW_EN
    .overflow(of8),
`endif
    .out_valid(ov8));

  full_adder #(.WIDTH(16)) u_w16 (
    .clk(clk), .rst(rst), .in_valid(v16), .a(a16), .b(b16), .carry_in(c16),
    .sum(s16), .carry_out(co16),
`ifdef FULL_ADDER_OVERFLOW_EN
    .overflow(of16),
`endif
    .out_valid(ov16));

  function automatic exp_t model(input int w, input logic [63:0] a,
                                 input logic [63:0] b, input logic cin);
    exp_t        r;
    logic [63:0] mask;
    logic [64:0] full;
    mask = (w == 64) ? '1 : ((64'd1 << w) - 64'd1);
    a    = a & mask;
    b    = b & mask;
    full = {1'b0, a} + {1'b0, b} + 65'(cin);
    r.s  = full[63:0] & mask;
    r.co = full[w];
    r.ov = (a[w-1] == b[w-1]) && (r.s[w-1] != a[w-1]);
    return r;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive1(input logic v, input logic a, input logic b, input logic c);
    v1 = v; a1 = a; b1 = b; c1 = c;
    if (v && !rst) q1.push_back(model(1, 64'(a), 64'(b), c));
  endtask

  task automatic drive8(input logic v, input logic [7:0] a, input logic [7:0] b, input logic c);
    v8 = v; a8 = a; b8 = b; c8 = c;
    if (v && !rst) q8.push_back(model(8, 64'(a), 64'(b), c));
  endtask

  task automatic drive16(input logic v, input logic [15:0] a, input logic [15:0] b, input logic c);
    fa_result_t r;
    v16 = v; a16 = a; b16 = b; c16 = c;
    if (v && !rst) begin
      r = fa_ref(a, b, c);
      q16.push_back('{s: 64'(r.sum), co: r.carry_out, ov: r.overflow});
    end
  endtask

  task automatic chk_reset_state();
    chk("rst_w1_sum", 64'(s1), 64'd0);
    chk("rst_w1_cout", 64'(co1), 64'd0);
    chk("rst_w1_valid", 64'(ov1), 64'd0);
    chk("rst_w8_valid", 64'(ov8), 64'd0);
    chk("rst_w16_valid", 64'(ov16), 64'd0);
  endtask

  // Monitors: pop the oldest pending expectation whenever a result is presented.
  always @(negedge clk) begin
    if (ov1) begin
      chk("w1_pending", 64'(q1.size() > 0), 64'd1);
      if (q1.size() > 0) begin
        e1 = q1.pop_front();
        chk("w1_sum", 64'(s1), e1.s);
        chk("w1_cout", 64'(co1), 64'(e1.co));
`ifdef FULL_ADDER_OVERFLOW_EN
        chk("w1_ovf", 64'(of1), 64'(e1.ov));
`endif
      end
    end
  end

  always @(negedge clk) begin
    if (ov8) begin
      chk("w8_pending", 64'(q8.size() > 0), 64'd1);
      if (q8.size() > 0) begin
        e8 = q8.pop_front();
        chk("w8_sum", 64'(s8), e8.s);
        chk("w8_cout", 64'(co8), 64'(e8.co));
`ifdef FULL_ADDER_OVERFLOW_EN
        chk("w8_ovf", 64'(of8), 64'(e8.ov));
`endif
      end
    end
  end

  always @(negedge clk) begin
    if (ov16) begin
      chk("w16_pending", 64'(q16.size() > 0), 64'd1);
      if (q16.size() > 0) begin
        e16 = q16.pop_front();
        chk("w16_sum", 64'(s16), e16.s);
        chk("w16_cout", 64'(co16), 64'(e16.co));
`ifdef FULL_ADDER_OVERFLOW_EN
        chk("w16_ovf", 64'(of16), 64'(e16.ov));
`endif
      end
    end
  end

  logic [2:0] tt [8];

  initial begin
    tt = '{3'b000, 3'b100, 3'b010, 3'b001, 3'b110, 3'b101, 3'b111, 3'b011};

    // Reset held two edges with live operands; nothing may be captured.
    drive1(1, 1, 1, 1);
    tick();
    chk_reset_state();
    tick();
    chk_reset_state();
    rst = 1'b0;
    drive1(1, 1, 1, 1);
    tick();
    chk("first_valid", 64'(ov1), 64'd1);

    foreach (tt[i]) begin
      drive1(1, tt[i][2], tt[i][1], tt[i][0]);
      tick();
    end
    drive1(0, 0, 0, 0);
    tick();

    drive8(1, 8'hFF, 8'h00, 1);
    tick();
    drive8(1, 8'h7F, 8'h01, 0);
    tick();
    drive8(1, 8'h80, 8'h80, 0);
    tick();
    drive8(1, 8'h2A, 8'h30, 0);
    tick();
    for (int i = 0; i < 3; i++) begin
      drive8(0, 8'($urandom), 8'($urandom), 1'($urandom));
      tick();
      chk("hold_valid", 64'(ov8), 64'd0);
      chk("hold_sum", 64'(s8), 64'h5A);
    end

    // Operands coincide with reset and must be dropped.
    rst = 1'b1;
    drive8(1, 8'h10, 8'h20, 0);
    tick();
    chk("midrst_valid", 64'(ov8), 64'd0);
    chk("midrst_sum", 64'(s8), 64'h00);
    rst = 1'b0;
    drive8(0, 8'h10, 8'h20, 0);
    tick();
    chk("midrst_after_valid", 64'(ov8), 64'd0);
    chk("midrst_after_sum", 64'(s8), 64'h00);

    for (int i = 0; i < 10000; i++) begin
      drive16(1'($urandom_range(0, 1)), 16'($urandom), 16'($urandom), 1'($urandom_range(0, 1)));
      tick();
    end
    drive16(0, 0, 0, 0);
    tick();
    tick();
    tick();

    chk("w1_drained", 64'(q1.size()), 64'd0);
    chk("w8_drained", 64'(q8.size()), 64'd0);
    chk("w16_drained", 64'(q16.size()), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

`default_nettype wire
